// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- two-entry pipeline register (main + skid) with flush.
//   Upstream beats arrive on in_valid/in_ready and leave in order on
//   out_valid/out_ready. out_* come straight from the main-entry flops and
//   in_ready depends only on state and flush, so the stage breaks timing
//   paths in both directions while still sustaining 1 beat/cycle.
// Ports:
//   clock, reset_n          clock, async active-low reset
//   flush                   synchronous discard of held and incoming beats
//   in_valid/in_ready       upstream handshake
//   in_ctrl/in_data/in_rd   upstream payload
//   out_valid/out_ready     downstream handshake
//   out_ctrl/out_data/out_rd downstream payload (zero when out_valid=0)
//   occupancy               beats held (0..2)
//   drop_count              valid beats discarded by flush, saturating
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            r_state;
  logic              r_rst_done;
  logic              r_main_vld, r_skid_vld;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data, r_skid_data;
  logic [RD_W-1:0]   r_main_rd,   r_skid_rd;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_accept, w_take;
  logic [1:0]        w_drop_n;
  logic [CNT_W:0]    w_drop_sum;

  // r_rst_done holds in_ready low through the first edge after reset release.
  assign in_ready   = r_rst_done & (r_state != FULL) & ~flush;
  assign w_accept   = in_valid & in_ready;
  assign w_take     = r_main_vld & out_ready;

  // Entries still held at a flush edge: main counts only if not taken.
  assign w_drop_n   = 2'(r_main_vld & ~w_take) + 2'(r_skid_vld);
  // One extra bit catches overflow; max + 2 never exceeds it.
  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_n);

  assign out_valid  = r_main_vld;
  assign out_ctrl   = r_main_ctrl;
  assign out_data   = r_main_data;
  assign out_rd     = r_main_rd;
  assign occupancy  = r_state;
  assign drop_count = r_drop_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_rst_done  <= 1'b0;
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_main_rd   <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_rd   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (flush) begin
        r_state     <= EMPTY;
        r_main_vld  <= 1'b0;
        r_skid_vld  <= 1'b0;
        r_main_ctrl <= '0;
        r_main_data <= '0;
        r_main_rd   <= '0;
        r_skid_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_rd   <= '0;
        r_drop_cnt  <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
      end else begin
        case (r_state)
          EMPTY: if (w_accept) begin
            r_state     <= ONE;
            r_main_vld  <= 1'b1;
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
            r_main_rd   <= in_rd;
          end
          ONE: begin
            if (w_accept && !w_take) begin
              r_state     <= FULL;
              r_skid_vld  <= 1'b1;
              r_skid_ctrl <= in_ctrl;
              r_skid_data <= in_data;
              r_skid_rd   <= in_rd;
            end else if (w_accept && w_take) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
              r_main_rd   <= in_rd;
            end else if (w_take) begin
              r_state     <= EMPTY;
              r_main_vld  <= 1'b0;
              r_main_ctrl <= '0;
              r_main_data <= '0;
              r_main_rd   <= '0;
            end
          end
          FULL: if (w_take) begin
            // in_ready is low in FULL, so only the skid can refill main.
            r_state     <= ONE;
            r_skid_vld  <= 1'b0;
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            r_main_rd   <= r_skid_rd;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_rd   <= '0;
          end
          default: begin
            r_state    <= EMPTY;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_ctrl;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  occupancy;
  logic [1:0]  drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(4), .RD_W(5), .CNT_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_rd(out_rd),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_dat;
    logic [1:0]  e_occ;
    logic        e_ir;
    logic [1:0]  e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, iv, input logic [31:0] din, input logic ordy,
                     input logic e_ov, input logic [31:0] e_dat, input logic [1:0] e_occ,
                     input logic e_ir, input logic [1:0] e_drop);
    vec_t v;
    v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.e_ov = e_ov; v.e_dat = e_dat; v.e_occ = e_occ; v.e_ir = e_ir; v.e_drop = e_drop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ov, input logic [31:0] e_dat,
                         input logic [1:0] e_occ, input logic e_ir, input logic [1:0] e_drop);
    logic [31:0] d;
    d = e_dat;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, " out_data"},  out_data, d);
    chk({tag, " out_ctrl"},  32'(out_ctrl), 32'(d[3:0]));
    chk({tag, " out_rd"},    32'(out_rd), 32'(d[4:0]));
    chk({tag, " occupancy"}, 32'(occupancy), 32'(e_occ));
    chk({tag, " in_ready"},  32'(in_ready), 32'(e_ir));
    chk({tag, " drop_count"}, 32'(drop_count), 32'(e_drop));
  endtask

  task automatic drive(input logic fl, iv, input logic [31:0] din, input logic ordy);
    flush = fl; in_valid = iv; in_data = din;
    in_ctrl = din[3:0]; in_rd = din[4:0]; out_ready = ordy;
  endtask

  initial begin
    //   fl iv data         ordy  ov data        occ ir drop
    // streaming, one cycle latency
    add(0, 1, 32'h1,    1,    1, 32'h1,    1, 1, 0);
    add(0, 1, 32'h2,    1,    1, 32'h2,    1, 1, 0);
    add(0, 1, 32'h3,    1,    1, 32'h3,    1, 1, 0);
    add(0, 1, 32'h4,    1,    1, 32'h4,    1, 1, 0);
    add(0, 0, 32'h0,    1,    0, 32'h0,    0, 1, 0);
    // backpressure: A then B into skid, C refused while FULL
    add(0, 1, 32'hAAAA, 0,    1, 32'hAAAA, 1, 1, 0);
    add(0, 1, 32'hBBBB, 0,    1, 32'hAAAA, 2, 0, 0);
    add(0, 1, 32'hCCCC, 0,    1, 32'hAAAA, 2, 0, 0);
    add(0, 1, 32'hCCCC, 1,    1, 32'hBBBB, 1, 1, 0);
    add(0, 0, 32'h0,    1,    0, 32'h0,    0, 1, 0);
    // flush in FULL drops 2, incoming beat lost
    add(0, 1, 32'h1111, 0,    1, 32'h1111, 1, 1, 0);
    add(0, 1, 32'h2222, 0,    1, 32'h1111, 2, 0, 0);
    add(1, 1, 32'h3333, 0,    0, 32'h0,    0, 0, 2);
    add(0, 0, 32'h0,    0,    0, 32'h0,    0, 1, 2);
    // flush with take: nothing dropped
    add(0, 1, 32'h4444, 1,    1, 32'h4444, 1, 1, 2);
    add(1, 1, 32'h5555, 1,    0, 32'h0,    0, 0, 2);
    // flush in EMPTY: incoming beat is not a held entry
    add(1, 1, 32'h6666, 1,    0, 32'h0,    0, 0, 2);
    // two-beat flushes saturate at 3
    add(0, 1, 32'h7,    0,    1, 32'h7,    1, 1, 2);
    add(0, 1, 32'h8,    0,    1, 32'h7,    2, 0, 2);
    add(1, 0, 32'h0,    0,    0, 32'h0,    0, 0, 3);
    for (int k = 0; k < 2; k++) begin
      add(0, 1, 32'h19, 0,    1, 32'h19,   1, 1, 3);
      add(0, 1, 32'h1A, 0,    1, 32'h19,   2, 0, 3);
      add(1, 0, 32'h0,  0,    0, 32'h0,    0, 0, 3);
    end
    // flush in ONE without take, already saturated
    add(0, 1, 32'h1B,   0,    1, 32'h1B,   1, 1, 3);
    add(1, 0, 32'h0,    0,    0, 32'h0,    0, 0, 3);
    add(0, 0, 32'h0,    0,    0, 32'h0,    0, 1, 3);

    // reset state
    #1 reset_n = 1'b0;
    #2 chk_all("reset", 0, 32'h0, 0, 0, 0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    #1 chk("post-release in_ready", 32'(in_ready), 32'h0);
    @(posedge clock); #1;
    chk("after first edge in_ready", 32'(in_ready), 32'h1);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      @(posedge clock); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_dat, vecs[i].e_occ,
              vecs[i].e_ir, vecs[i].e_drop);
    end

    // async reset while FULL with ctrl=0xF
    @(negedge clock); drive(0, 1, 32'h1F, 0);
    @(negedge clock); drive(0, 1, 32'h2F, 0);
    @(posedge clock); #1;
    chk_all("fill", 1, 32'h1F, 2, 0, 3);
    drive(0, 0, 32'h0, 0);
    #1 reset_n = 1'b0;
    #1 chk_all("async reset", 0, 32'h0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 1, 32'h77, 1);
    @(posedge clock); #1;
    chk("reset2 in_ready", 32'(in_ready), 32'h1);
    @(posedge clock); #1;
    chk_all("reset2 accept", 1, 32'h77, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
